// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: ALU op bit indices,
// mem_inst bit positions and the divider state encoding.
package exe_stage_pkg;

  localparam int ALU_OPS   = 19;
  localparam int ALU_ADD   = 0;
  localparam int ALU_SUB   = 1;
  localparam int ALU_SLT   = 2;
  localparam int ALU_SLTU  = 3;
  localparam int ALU_AND   = 4;
  localparam int ALU_NOR   = 5;
  localparam int ALU_OR    = 6;
  localparam int ALU_XOR   = 7;
  localparam int ALU_SLL   = 8;
  localparam int ALU_SRL   = 9;
  localparam int ALU_SRA   = 10;
  localparam int ALU_LU12I = 11;
  localparam int ALU_MUL   = 12;
  localparam int ALU_MULH  = 13;
  localparam int ALU_MULHU = 14;
  localparam int ALU_DIV   = 15;
  localparam int ALU_DIVU  = 16;
  localparam int ALU_MOD   = 17;
  localparam int ALU_MODU  = 18;

  // mem_inst = {st_b, st_h, st_w, ld_b, ld_bu, ld_h, ld_hu, ld_w}
  localparam int MEM_LD_W  = 0;
  localparam int MEM_LD_HU = 1;
  localparam int MEM_LD_H  = 2;
  localparam int MEM_LD_BU = 3;
  localparam int MEM_LD_B  = 4;
  localparam int MEM_ST_W  = 5;
  localparam int MEM_ST_H  = 6;
  localparam int MEM_ST_B  = 7;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_iter.sv
// Iterative restoring divider: 32 steps on absolute values, sign fix-up on
// the way out. Result stays stable in DONE until ack.
module div_iter
  import exe_stage_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        signed_op,
  input  logic        ack,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  div_state_e  r_state;
  div_state_e  w_next;
  logic [4:0]  r_cnt;
  logic [31:0] r_quo;
  logic [31:0] r_rem;
  logic [31:0] r_dsor;
  logic        r_neg_q;
  logic        r_neg_r;

  logic [31:0] w_a_abs;
  logic [31:0] w_b_abs;
  logic [32:0] w_shift;
  logic [32:0] w_diff;

  assign w_a_abs = (signed_op && dividend[31]) ? -dividend : dividend;
  assign w_b_abs = (signed_op && divisor[31])  ? -divisor  : divisor;

  // One restoring step: shift next dividend bit into the partial remainder.
  assign w_shift = {r_rem, r_quo[31]};
  assign w_diff  = w_shift - {1'b0, r_dsor};

  // Next-state logic for the divider FSM.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      DIV_IDLE: if (start)            w_next = DIV_BUSY;
      DIV_BUSY: if (r_cnt == 5'd31)   w_next = DIV_DONE;
      DIV_DONE: if (ack)              w_next = DIV_IDLE;
      default:                        w_next = DIV_IDLE;
    endcase
  end

  // State register, step counter and datapath registers.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= DIV_IDLE;
      r_cnt   <= 5'd0;
      r_quo   <= 32'd0;
      r_rem   <= 32'd0;
      r_dsor  <= 32'd0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == DIV_IDLE && start) begin
        r_cnt   <= 5'd0;
        r_quo   <= w_a_abs;
        r_rem   <= 32'd0;
        r_dsor  <= w_b_abs;
        // A zero divisor keeps the all-ones quotient unsigned-looking.
        r_neg_q <= signed_op && (dividend[31] ^ divisor[31]) && (divisor != 32'd0);
        r_neg_r <= signed_op && dividend[31];
      end else if (r_state == DIV_BUSY) begin
        r_cnt <= r_cnt + 5'd1;
        if (!w_diff[32]) begin
          r_rem <= w_diff[31:0];
          r_quo <= {r_quo[30:0], 1'b1};
        end else begin
          r_rem <= w_shift[31:0];
          r_quo <= {r_quo[30:0], 1'b0};
        end
      end
    end
  end

  assign busy      = (r_state == DIV_BUSY);
  assign done      = (r_state == DIV_DONE);
  assign quotient  = r_neg_q ? -r_quo : r_quo;
  assign remainder = r_neg_r ? -r_rem : r_rem;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: latches the decode payload, computes ALU / multiply /
// iterative-divide results, issues the data-SRAM request and hands on to MEM.
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic                ds_to_es_valid,
  output logic                es_allowin,
  input  logic [31:0]         ds_pc,
  input  logic [ALU_OPS-1:0]  ds_alu_op,
  input  logic                ds_res_from_mem,
  input  logic [31:0]         ds_alu_src1,
  input  logic [31:0]         ds_alu_src2,
  input  logic [31:0]         ds_rkd_value,
  input  logic                ds_mem_we,
  input  logic                ds_rf_we,
  input  logic [4:0]          ds_rf_waddr,
  input  logic [7:0]          mem_inst,
  input  logic                ms_allowin,
  output logic                es_to_ms_valid,
  output logic [31:0]         es_pc,
  output logic [31:0]         es_alu_result,
  output logic                es_res_from_mem,
  output logic                es_rf_we,
  output logic [4:0]          es_rf_waddr,
  output logic [4:0]          es_ld_inst,
  output logic [1:0]          es_addr_lo,
  output logic                data_sram_en,
  output logic [3:0]          data_sram_we,
  output logic [31:0]         data_sram_addr,
  output logic [31:0]         data_sram_wdata
);

  logic               r_es_valid;
  logic [31:0]        r_pc;
  logic [ALU_OPS-1:0] r_alu_op;
  logic               r_res_from_mem;
  logic [31:0]        r_src1;
  logic [31:0]        r_src2;
  logic [31:0]        r_rkd;
  logic               r_mem_we;
  logic               r_rf_we;
  logic [4:0]         r_rf_waddr;
  logic [7:0]         r_mem_inst;

  logic               w_ready_go;
  logic               w_is_div;
  logic               w_div_signed;
  logic               w_div_start;
  logic               w_div_busy;
  logic               w_div_done;
  logic [31:0]        w_quotient;
  logic [31:0]        w_remainder;
  logic [4:0]         w_shamt;
  logic [31:0]        w_sra;
  logic               w_mul_signed;
  logic [63:0]        w_prod;
  logic [31:0]        w_alu_result;
  logic [3:0]         w_st_we;
  logic [31:0]        w_st_wdata;

  // Payload registers and the stage valid bit.
  // NOTE: payload registers are reset too, so outputs are defined from reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_es_valid     <= 1'b0;
      r_pc           <= 32'd0;
      r_alu_op       <= '0;
      r_res_from_mem <= 1'b0;
      r_src1         <= 32'd0;
      r_src2         <= 32'd0;
      r_rkd          <= 32'd0;
      r_mem_we       <= 1'b0;
      r_rf_we        <= 1'b0;
      r_rf_waddr     <= 5'd0;
      r_mem_inst     <= 8'd0;
    end else begin
      if (es_allowin) r_es_valid <= ds_to_es_valid;
      if (es_allowin && ds_to_es_valid) begin
        r_pc           <= ds_pc;
        r_alu_op       <= ds_alu_op;
        r_res_from_mem <= ds_res_from_mem;
        r_src1         <= ds_alu_src1;
        r_src2         <= ds_alu_src2;
        r_rkd          <= ds_rkd_value;
        r_mem_we       <= ds_mem_we;
        r_rf_we        <= ds_rf_we;
        r_rf_waddr     <= ds_rf_waddr;
        r_mem_inst     <= mem_inst;
      end
    end
  end

  assign w_is_div     = |r_alu_op[ALU_MODU:ALU_DIV];
  assign w_div_signed = r_alu_op[ALU_DIV] | r_alu_op[ALU_MOD];
  assign w_div_start  = r_es_valid & w_is_div & ~w_div_busy & ~w_div_done;
  assign w_ready_go   = ~w_is_div | w_div_done;

  assign es_allowin     = ~r_es_valid | (w_ready_go & ms_allowin);
  assign es_to_ms_valid = r_es_valid & w_ready_go;

  div_iter u_div (
    .clk       (clk),
    .resetn    (resetn),
    .start     (w_div_start),
    .signed_op (w_div_signed),
    .ack       (ms_allowin),
    .dividend  (r_src1),
    .divisor   (r_src2),
    .busy      (w_div_busy),
    .done      (w_div_done),
    .quotient  (w_quotient),
    .remainder (w_remainder)
  );

  // One shared 64x64 multiplier; operands are sign-extended only for mulh,
  // the low half is identical for mul either way.
  assign w_mul_signed = r_alu_op[ALU_MULH];
  assign w_prod = {{32{w_mul_signed & r_src1[31]}}, r_src1}
                * {{32{w_mul_signed & r_src2[31]}}, r_src2};

  assign w_shamt = r_src2[4:0];
  assign w_sra   = 32'($signed(r_src1) >>> w_shamt);

  // Result select on the one-hot op.
  always_comb begin
    w_alu_result = 32'd0;
    if (r_alu_op[ALU_ADD])   w_alu_result = r_src1 + r_src2;
    if (r_alu_op[ALU_SUB])   w_alu_result = r_src1 - r_src2;
    if (r_alu_op[ALU_SLT])   w_alu_result = {31'd0, $signed(r_src1) < $signed(r_src2)};
    if (r_alu_op[ALU_SLTU])  w_alu_result = {31'd0, r_src1 < r_src2};
    if (r_alu_op[ALU_AND])   w_alu_result = r_src1 & r_src2;
    if (r_alu_op[ALU_NOR])   w_alu_result = ~(r_src1 | r_src2);
    if (r_alu_op[ALU_OR])    w_alu_result = r_src1 | r_src2;
    if (r_alu_op[ALU_XOR])   w_alu_result = r_src1 ^ r_src2;
    if (r_alu_op[ALU_SLL])   w_alu_result = r_src1 << w_shamt;
    if (r_alu_op[ALU_SRL])   w_alu_result = r_src1 >> w_shamt;
    if (r_alu_op[ALU_SRA])   w_alu_result = w_sra;
    if (r_alu_op[ALU_LU12I]) w_alu_result = r_src2;
    if (r_alu_op[ALU_MUL])   w_alu_result = w_prod[31:0];
    if (r_alu_op[ALU_MULH] || r_alu_op[ALU_MULHU]) w_alu_result = w_prod[63:32];
    if (r_alu_op[ALU_DIV] || r_alu_op[ALU_DIVU])   w_alu_result = w_quotient;
    if (r_alu_op[ALU_MOD] || r_alu_op[ALU_MODU])   w_alu_result = w_remainder;
  end

  // Store byte enables and lane replication from the low address bits.
  always_comb begin
    w_st_we    = 4'b0000;
    w_st_wdata = r_rkd;
    if (r_mem_inst[MEM_ST_W]) begin
      w_st_we = 4'b1111;
    end else if (r_mem_inst[MEM_ST_H]) begin
      w_st_we    = w_alu_result[1] ? 4'b1100 : 4'b0011;
      w_st_wdata = {2{r_rkd[15:0]}};
    end else if (r_mem_inst[MEM_ST_B]) begin
      w_st_we    = 4'b0001 << w_alu_result[1:0];
      w_st_wdata = {4{r_rkd[7:0]}};
    end
  end

  // Request only on the handshake cycle so it is issued exactly once.
  assign data_sram_en    = r_es_valid & w_ready_go & ms_allowin & (r_res_from_mem | r_mem_we);
  assign data_sram_we    = (data_sram_en & r_mem_we) ? w_st_we : 4'b0000;
  assign data_sram_addr  = w_alu_result;
  assign data_sram_wdata = w_st_wdata;

  assign es_pc           = r_pc;
  assign es_alu_result   = w_alu_result;
  assign es_res_from_mem = r_es_valid & r_res_from_mem;
  assign es_rf_we        = r_es_valid & r_rf_we;
  assign es_rf_waddr     = r_rf_waddr;
  assign es_ld_inst      = r_mem_inst[4:0];
  assign es_addr_lo      = w_alu_result[1:0];

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: ALU, multiply, divide timing/results,
// store alignment, DONE hold with back-pressure and reset mid-divide.
module tb_exe_stage;
  import exe_stage_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ds_to_es_valid;
  logic        es_allowin;
  logic [31:0] ds_pc;
  logic [18:0] ds_alu_op;
  logic        ds_res_from_mem;
  logic [31:0] ds_alu_src1;
  logic [31:0] ds_alu_src2;
  logic [31:0] ds_rkd_value;
  logic        ds_mem_we;
  logic        ds_rf_we;
  logic [4:0]  ds_rf_waddr;
  logic [7:0]  mem_inst;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [31:0] es_pc;
  logic [31:0] es_alu_result;
  logic        es_res_from_mem;
  logic        es_rf_we;
  logic [4:0]  es_rf_waddr;
  logic [4:0]  es_ld_inst;
  logic [1:0]  es_addr_lo;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  exe_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .ds_to_es_valid  (ds_to_es_valid),
    .es_allowin      (es_allowin),
    .ds_pc           (ds_pc),
    .ds_alu_op       (ds_alu_op),
    .ds_res_from_mem (ds_res_from_mem),
    .ds_alu_src1     (ds_alu_src1),
    .ds_alu_src2     (ds_alu_src2),
    .ds_rkd_value    (ds_rkd_value),
    .ds_mem_we       (ds_mem_we),
    .ds_rf_we        (ds_rf_we),
    .ds_rf_waddr     (ds_rf_waddr),
    .mem_inst        (mem_inst),
    .ms_allowin      (ms_allowin),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_pc           (es_pc),
    .es_alu_result   (es_alu_result),
    .es_res_from_mem (es_res_from_mem),
    .es_rf_we        (es_rf_we),
    .es_rf_waddr     (es_rf_waddr),
    .es_ld_inst      (es_ld_inst),
    .es_addr_lo      (es_addr_lo),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ds();
    ds_to_es_valid  = 1'b0;
    ds_pc           = 32'd0;
    ds_alu_op       = '0;
    ds_res_from_mem = 1'b0;
    ds_alu_src1     = 32'd0;
    ds_alu_src2     = 32'd0;
    ds_rkd_value    = 32'd0;
    ds_mem_we       = 1'b0;
    ds_rf_we        = 1'b0;
    ds_rf_waddr     = 5'd0;
    mem_inst        = 8'd0;
  endtask

  task automatic drive_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    clear_ds();
    ds_to_es_valid   = 1'b1;
    ds_pc            = 32'h1c00_0000 + 32'(op * 4);
    ds_alu_op[op]    = 1'b1;
    ds_alu_src1      = a;
    ds_alu_src2      = b;
    ds_rf_we         = 1'b1;
    ds_rf_waddr      = 5'd3;
  endtask

  task automatic run_single(input string tag, input int op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp);
    drive_alu(op, a, b);
    step();
    ds_to_es_valid = 1'b0;
    check(tag, es_alu_result, exp);
    check({tag, "_vld"}, {31'd0, es_to_ms_valid}, 32'd1);
    step();
  endtask

  // Count samples until es_to_ms_valid rises; also count samples where
  // es_allowin was wrongly high while waiting.
  task automatic wait_ready(output int n, output int n_hi);
    n = 0;
    n_hi = 0;
    while (!es_to_ms_valid && n < 200) begin
      if (es_allowin) n_hi++;
      n++;
      step();
    end
  endtask

  task automatic run_div(input string tag, input int op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    int n, n_hi;
    drive_alu(op, a, b);
    step();
    ds_to_es_valid = 1'b0;
    wait_ready(n, n_hi);
    check({tag, "_lat"}, 32'(n), 32'd33);
    check({tag, "_res"}, es_alu_result, exp);
    step();
  endtask

  task automatic run_mem(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] rkd, input logic [7:0] mi, input logic st,
                         input logic [3:0] exp_we, input logic chk_wdata,
                         input logic [31:0] exp_wdata);
    drive_alu(ALU_ADD, a, b);
    ds_rkd_value    = rkd;
    mem_inst        = mi;
    ds_mem_we       = st;
    ds_res_from_mem = ~st;
    ds_rf_we        = ~st;
    step();
    ds_to_es_valid = 1'b0;
    check({tag, "_en"}, {31'd0, data_sram_en}, 32'd1);
    check({tag, "_we"}, {28'd0, data_sram_we}, {28'd0, exp_we});
    check({tag, "_addr"}, data_sram_addr, a + b);
    if (chk_wdata) check({tag, "_wdata"}, data_sram_wdata, exp_wdata);
    step();
    check({tag, "_en_off"}, {31'd0, data_sram_en}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, n_hi;
    logic [1:0] st;

    clear_ds();
    ms_allowin = 1'b1;
    resetn = 1'b0;
    repeat (3) step();

    // Reset state.
    check("rst_allowin", {31'd0, es_allowin}, 32'd1);
    check("rst_to_ms", {31'd0, es_to_ms_valid}, 32'd0);
    check("rst_rf_we", {31'd0, es_rf_we}, 32'd0);
    check("rst_res_mem", {31'd0, es_res_from_mem}, 32'd0);
    check("rst_sram_en", {31'd0, data_sram_en}, 32'd0);
    check("rst_sram_we", {28'd0, data_sram_we}, 32'd0);
    check("rst_pc", es_pc, 32'd0);
    check("rst_es_valid", {31'd0, dut.r_es_valid}, 32'd0);
    st = dut.u_div.r_state;
    check("rst_state", {30'd0, st}, {30'd0, DIV_IDLE});
    check("rst_cnt", {27'd0, dut.u_div.r_cnt}, 32'd0);
    resetn = 1'b1;
    step();

    // add 7 + (-2): one cycle in EX, valid to MEM for one cycle.
    drive_alu(ALU_ADD, 32'd7, 32'hFFFF_FFFE);
    step();
    ds_to_es_valid = 1'b0;
    check("add_res", es_alu_result, 32'd5);
    check("add_vld", {31'd0, es_to_ms_valid}, 32'd1);
    check("add_rf_we", {31'd0, es_rf_we}, 32'd1);
    check("add_waddr", {27'd0, es_rf_waddr}, 32'd3);
    check("add_pc", es_pc, 32'h1c00_0000);
    check("add_sram_en", {31'd0, data_sram_en}, 32'd0);
    step();
    check("add_vld_off", {31'd0, es_to_ms_valid}, 32'd0);

    run_single("sub",   ALU_SUB,   32'd3,          32'd5,          32'hFFFF_FFFE);
    run_single("slt",   ALU_SLT,   32'hFFFF_FFFF,  32'd1,          32'd1);
    run_single("sltu",  ALU_SLTU,  32'hFFFF_FFFF,  32'd1,          32'd0);
    run_single("nor",   ALU_NOR,   32'h0000_00F0,  32'h0F00_0000,  32'hF0FF_FF0F);
    run_single("xor",   ALU_XOR,   32'hFF00_FF00,  32'h0FF0_0FF0,  32'hF0F0_F0F0);
    run_single("sll",   ALU_SLL,   32'd1,          32'h0000_003F,  32'h8000_0000);
    run_single("srl",   ALU_SRL,   32'h8000_0000,  32'd4,          32'h0800_0000);
    run_single("sra",   ALU_SRA,   32'h8000_0000,  32'd4,          32'hF800_0000);
    run_single("lu12i", ALU_LU12I, 32'h1234_5678,  32'hABCD_E000,  32'hABCD_E000);
    run_single("mul",   ALU_MUL,   32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1);
    run_single("mulh",  ALU_MULH,  32'h8000_0000,  32'd2,          32'hFFFF_FFFF);
    run_single("mulhu", ALU_MULHU, 32'h8000_0000,  32'd2,          32'h0000_0001);

    // Back-to-back div then mod of -7 / 2; mod waits in decode meanwhile.
    drive_alu(ALU_DIV, 32'hFFFF_FFF9, 32'd2);
    step();
    drive_alu(ALU_MOD, 32'hFFFF_FFF9, 32'd2);
    wait_ready(n, n_hi);
    check("div_lat", 32'(n), 32'd33);
    check("div_allowin_lo", 32'(n_hi), 32'd0);
    check("div_res", es_alu_result, 32'hFFFF_FFFD);
    step();
    ds_to_es_valid = 1'b0;
    st = dut.u_div.r_state;
    check("b2b_state", {30'd0, st}, {30'd0, DIV_IDLE});
    check("b2b_valid", {31'd0, dut.r_es_valid}, 32'd1);
    wait_ready(n, n_hi);
    check("mod_lat", 32'(n), 32'd33);
    check("mod_res", es_alu_result, 32'hFFFF_FFFF);
    step();

    run_div("divu_z", ALU_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF);
    run_div("modu_z", ALU_MODU, 32'd5,         32'd0,         32'd5);
    run_div("div_z",  ALU_DIV,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF);
    run_div("mod_z",  ALU_MOD,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9);
    run_div("div_ov", ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_div("mod_ov", ALU_MOD,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run_div("divu",   ALU_DIVU, 32'hFFFF_FFFF, 32'd16,        32'h0FFF_FFFF);

    // Stores and a load.
    run_mem("st_b", 32'h0000_1000, 32'd3, 32'h1234_5678, 8'b1000_0000, 1'b1,
            4'b1000, 1'b1, 32'h7878_7878);
    run_mem("st_h", 32'h0000_1000, 32'd2, 32'h1234_5678, 8'b0100_0000, 1'b1,
            4'b1100, 1'b1, 32'h5678_5678);
    run_mem("st_w", 32'h0000_2000, 32'd4, 32'hDEAD_BEEF, 8'b0010_0000, 1'b1,
            4'b1111, 1'b1, 32'hDEAD_BEEF);
    run_mem("ld_w", 32'h0000_3000, 32'd8, 32'h0,         8'b0000_0001, 1'b0,
            4'b0000, 1'b0, 32'h0);

    // Divide held in DONE under back-pressure, tagged as a load so the
    // single request at the handshake is visible.
    ms_allowin = 1'b0;
    drive_alu(ALU_DIV, 32'd100, 32'd7);
    ds_res_from_mem = 1'b1;
    mem_inst = 8'b0000_0001;
    step();
    ds_to_es_valid = 1'b0;
    wait_ready(n, n_hi);
    check("hold_lat", 32'(n), 32'd33);
    for (int i = 0; i < 5; i++) begin
      check("hold_res", es_alu_result, 32'd14);
      check("hold_vld", {31'd0, es_to_ms_valid}, 32'd1);
      check("hold_sram_en", {31'd0, data_sram_en}, 32'd0);
      check("hold_allowin", {31'd0, es_allowin}, 32'd0);
      step();
    end
    ms_allowin = 1'b1;
    #1;
    check("rel_allowin", {31'd0, es_allowin}, 32'd1);
    check("rel_sram_en", {31'd0, data_sram_en}, 32'd1);
    check("rel_ld_inst", {27'd0, es_ld_inst}, 32'd1);
    step();
    st = dut.u_div.r_state;
    check("rel_state", {30'd0, st}, {30'd0, DIV_IDLE});
    check("rel_sram_off", {31'd0, data_sram_en}, 32'd0);

    // Reset in BUSY cycle 10 abandons the divide.
    drive_alu(ALU_DIVU, 32'd1000, 32'd3);
    step();
    ds_to_es_valid = 1'b0;
    repeat (10) step();
    st = dut.u_div.r_state;
    check("mid_busy", {30'd0, st}, {30'd0, DIV_BUSY});
    resetn = 1'b0;
    step();
    check("mid_valid", {31'd0, dut.r_es_valid}, 32'd0);
    st = dut.u_div.r_state;
    check("mid_state", {30'd0, st}, {30'd0, DIV_IDLE});
    check("mid_allowin", {31'd0, es_allowin}, 32'd1);
    resetn = 1'b1;
    step();
    run_div("post_rst", ALU_DIVU, 32'd1000, 32'd3, 32'd333);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
